// File: rtl/fetch_prefetch_q_if.sv
// Instruction-memory request/grant bus used by the fetch front end.
// The fetch unit is the master; the instruction memory is the slave.
interface fetch_prefetch_q_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_prefetch_q.sv
// Instruction-fetch front end with a decoupling prefetch queue.
// Issues sequential word-aligned fetches, buffers in-order responses with
// their PCs, and hands them to decode over valid/ready. A redirect flushes
// the queue and marks every in-flight response for discard.
module fetch_prefetch_q #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  fetch_prefetch_q_if.master       mem,
  output logic                     instr_valid_o,
  output logic [ILEN-1:0]          instr_o,
  output logic [XLEN-1:0]          pc_o,
  input  logic                     instr_ready_i,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   drop_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] resp_pc_q;

  logic [CW:0]     occupancy;
  logic            gnt_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] redirect_target;
  entry_t          head;

  // The low target bits are architecturally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign redirect_target      = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Queued plus in-flight never exceeds DEPTH, which is why a push is never refused.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};

  // Requests are held off during reset so the bus stays quiet while the
  // counters (which would otherwise permit issue) are being cleared.
  assign mem.req  = rst_n_i && !redirect_i && (occupancy < DEPTH_W);
  assign mem.addr = fetch_pc_q;
  assign gnt_fire = mem.req && mem.gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = mem.rvalid && (inflight_q != '0);

  assign head_valid = (count_q != '0);
  assign push       = rsp_fire && (drop_q == '0) && !redirect_i;
  assign pop        = head_valid && instr_ready_i && !redirect_i;
  assign head       = q_mem[rd_ptr_q];

  // Present the queue head; outputs are zero whenever the queue is empty.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    instr_valid_o = head_valid;
    instr_o       = '0;
    pc_o          = '0;
    if (head_valid) begin
      instr_o = head.instr;
      pc_o    = head.pc;
    end
  end

  assign stall_o = !head_valid;
  assign count_o = count_q;

  // Fetch/response PCs, queue pointers and the in-flight/drop bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_q + CW'(gnt_fire) - CW'(rsp_fire);
      if (redirect_i) begin
        fetch_pc_q <= redirect_target;
        resp_pc_q  <= redirect_target;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        // Everything still outstanding after this cycle belongs to the old path.
        drop_q     <= drop_q + inflight_q - CW'(rsp_fire);
      end else begin
        if (gnt_fire) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
        if (rsp_fire) begin
          if (drop_q != '0) begin
            drop_q <= drop_q - CW'(1);
          end else begin
            resp_pc_q <= resp_pc_q + XLEN'(4);
          end
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage: written on push only.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; count_q alone decides which entries are meaningful.
    if (push) begin
      q_mem[wr_ptr_q] <= '{pc: resp_pc_q, instr: mem.rdata};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Directed, table-driven bench for fetch_prefetch_q (DEPTH=4, RESET_PC=0).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge, so each table row describes one full clock cycle.
module tb_fetch_prefetch_q;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_n_i;
  logic                   redirect_i;
  logic [XLEN-1:0]        redirect_pc_i;
  logic                   instr_valid_o;
  logic [ILEN-1:0]        instr_o;
  logic [XLEN-1:0]        pc_o;
  logic                   instr_ready_i;
  logic                   stall_o;
  logic [$clog2(DEPTH):0] count_o;

  fetch_prefetch_q_if #(.XLEN(XLEN), .ILEN(ILEN)) mem_if ();

  fetch_prefetch_q #(
    .XLEN    (XLEN),
    .ILEN    (ILEN),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem          (mem_if),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .instr_ready_i(instr_ready_i),
    .stall_o      (stall_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction word the modelled memory returns for a given address.
  function automatic logic [31:0] idata(input logic [31:0] addr);
    return addr ^ 32'h5EED_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bench-side count of granted-but-unanswered requests, used to flag
  // responses that arrive with nothing outstanding.
  int outstanding;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outstanding <= 0;
    end else begin
      if (mem_if.rvalid) begin
        assert (outstanding != 0) else $error("protocol error: rvalid with no request outstanding");
      end
      outstanding <= outstanding + int'(mem_if.req && mem_if.gnt) - int'(mem_if.rvalid);
    end
  end

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] raddr;   // address whose instruction is returned this cycle
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [31:0] rpc, input logic g, input logic rv,
    input logic [31:0] ra, input logic rdy, input logic er, input logic [31:0] ea,
    input logic ev, input logic [31:0] ep, input logic [2:0] ec);
    vec_t v;
    v.redir = r;  v.rpc = rpc;  v.gnt = g;  v.rvalid = rv;  v.raddr = ra;  v.ready = rdy;
    v.exp_req = er;  v.exp_addr = ea;  v.exp_valid = ev;  v.exp_pc = ep;  v.exp_count = ec;
    return v;
  endfunction

  task automatic drive_idle();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = '0;
    instr_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] pend_addr;
    logic        pend;
    logic        filled;

    //          redir rpc           gnt rv raddr         rdy | req addr          vld pc            cnt
    // Streaming with 1-cycle latency, then a downstream stall fills the queue.
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h0,         0, 32'h0,         0)); // 0
    vecs.push_back(mk(0, 0,            1, 1, 32'h0,        1,  1, 32'h4,         0, 32'h0,         0)); // 1
    vecs.push_back(mk(0, 0,            1, 1, 32'h4,        1,  1, 32'h8,         1, 32'h0,         1)); // 2
    vecs.push_back(mk(0, 0,            1, 1, 32'h8,        1,  1, 32'hC,         1, 32'h4,         1)); // 3
    vecs.push_back(mk(0, 0,            1, 1, 32'hC,        0,  1, 32'h10,        1, 32'h8,         1)); // 4
    vecs.push_back(mk(0, 0,            1, 1, 32'h10,       0,  1, 32'h14,        1, 32'h8,         2)); // 5
    vecs.push_back(mk(0, 0,            1, 1, 32'h14,       0,  0, 32'h18,        1, 32'h8,         3)); // 6
    vecs.push_back(mk(0, 0,            1, 0, 0,            0,  0, 32'h18,        1, 32'h8,         4)); // 7 full
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  0, 32'h18,        1, 32'h8,         4)); // 8 one pop
    vecs.push_back(mk(0, 0,            1, 0, 0,            0,  1, 32'h18,        1, 32'hC,         3)); // 9 one request
    vecs.push_back(mk(0, 0,            1, 0, 0,            0,  0, 32'h1C,        1, 32'hC,         3)); // 10
    vecs.push_back(mk(0, 0,            0, 1, 32'h18,       0,  0, 32'h1C,        1, 32'hC,         3)); // 11
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  0, 32'h1C,        1, 32'hC,         4)); // 12
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h1C,        1, 32'h10,        3)); // 13
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h1C,        1, 32'h14,        2)); // 14
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h1C,        1, 32'h18,        1)); // 15
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h1C,        0, 32'h0,         0)); // 16
    // Three requests in flight, redirect to 0x103: stale responses dropped.
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h1C,        0, 32'h0,         0)); // 17
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h20,        0, 32'h0,         0)); // 18
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h24,        0, 32'h0,         0)); // 19
    vecs.push_back(mk(1, 32'h103,      1, 0, 0,            1,  0, 32'h28,        0, 32'h0,         0)); // 20 redirect
    vecs.push_back(mk(0, 0,            0, 1, 32'h1C,       1,  1, 32'h100,       0, 32'h0,         0)); // 21 stale
    vecs.push_back(mk(0, 0,            1, 1, 32'h20,       1,  1, 32'h100,       0, 32'h0,         0)); // 22 stale
    vecs.push_back(mk(0, 0,            0, 1, 32'h24,       1,  1, 32'h104,       0, 32'h0,         0)); // 23 stale
    vecs.push_back(mk(0, 0,            0, 1, 32'h100,      1,  1, 32'h104,       0, 32'h0,         0)); // 24
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h104,       1, 32'h100,       1)); // 25
    // Redirect coinciding with a response and a pop (drop = inflight - 1 = 1).
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h104,       0, 32'h0,         0)); // 26
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h108,       0, 32'h0,         0)); // 27
    vecs.push_back(mk(0, 0,            1, 1, 32'h104,      1,  1, 32'h10C,       0, 32'h0,         0)); // 28
    vecs.push_back(mk(1, 32'h200,      1, 1, 32'h108,      1,  0, 32'h110,       1, 32'h104,       1)); // 29 redirect
    vecs.push_back(mk(0, 0,            0, 1, 32'h10C,      1,  1, 32'h200,       0, 32'h0,         0)); // 30 stale
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'h200,       0, 32'h0,         0)); // 31
    vecs.push_back(mk(0, 0,            0, 1, 32'h200,      1,  1, 32'h204,       0, 32'h0,         0)); // 32
    vecs.push_back(mk(0, 0,            0, 0, 0,            1,  1, 32'h204,       1, 32'h200,       1)); // 33
    // Address wrap from 0xFFFFFFFC; target low bits ignored.
    vecs.push_back(mk(1, 32'hFFFFFFFE, 0, 0, 0,            1,  0, 32'h204,       0, 32'h0,         0)); // 34
    vecs.push_back(mk(0, 0,            1, 0, 0,            1,  1, 32'hFFFFFFFC,  0, 32'h0,         0)); // 35
    vecs.push_back(mk(0, 0,            0, 1, 32'hFFFFFFFC, 1,  1, 32'h0,         0, 32'h0,         0)); // 36
    vecs.push_back(mk(0, 0,            0, 0, 0,            0,  1, 32'h0,         1, 32'hFFFFFFFC,  1)); // 37

    // Reset state while reset is held.
    rst_n_i = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset req",   mem_if.req,    1'b0);
    check("reset valid", instr_valid_o, 1'b0);
    check("reset instr", instr_o,       32'h0);
    check("reset pc",    pc_o,          32'h0);
    check("reset stall", stall_o,       1'b1);
    check("reset count", count_o,       3'd0);
    rst_n_i = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      mem_if.gnt    = vecs[i].gnt;
      mem_if.rvalid = vecs[i].rvalid;
      mem_if.rdata  = vecs[i].rvalid ? idata(vecs[i].raddr) : 32'h0;
      instr_ready_i = vecs[i].ready;
      @(negedge clk_i);
      check($sformatf("v%0d req", i),   mem_if.req,    vecs[i].exp_req);
      check($sformatf("v%0d addr", i),  mem_if.addr,   vecs[i].exp_addr);
      check($sformatf("v%0d valid", i), instr_valid_o, vecs[i].exp_valid);
      check($sformatf("v%0d stall", i), stall_o,       !vecs[i].exp_valid);
      check($sformatf("v%0d pc", i),    pc_o,          vecs[i].exp_pc);
      check($sformatf("v%0d instr", i), instr_o,
            vecs[i].exp_valid ? idata(vecs[i].exp_pc) : 32'h0);
      check($sformatf("v%0d count", i), count_o,      vecs[i].exp_count);
      @(posedge clk_i);
      #1;
    end

    // Fill the queue with decode stalled, using a 1-cycle-latency memory.
    pend      = 1'b0;
    pend_addr = '0;
    filled    = 1'b0;
    for (int c = 0; c < 20 && !filled; c++) begin
      drive_idle();
      mem_if.gnt    = 1'b1;
      mem_if.rvalid = pend;
      mem_if.rdata  = pend ? idata(pend_addr) : 32'h0;
      @(negedge clk_i);
      if (count_o == 3'd4 && !mem_if.req) filled = 1'b1;
      pend      = mem_if.req;
      pend_addr = mem_if.addr;
      @(posedge clk_i);
      #1;
    end
    check("fill reached", filled, 1'b1);
    drive_idle();
    check("full count", count_o,    3'd4);
    check("full req",   mem_if.req, 1'b0);
    check("full head",  pc_o,       32'hFFFFFFFC);

    // Asynchronous reset mid-cycle: outputs clear with no clock edge.
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async req",   mem_if.req,    1'b0);
    check("async valid", instr_valid_o, 1'b0);
    check("async instr", instr_o,       32'h0);
    check("async pc",    pc_o,          32'h0);
    check("async stall", stall_o,       1'b1);
    check("async count", count_o,       3'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // Fetch restarts at RESET_PC.
    mem_if.gnt    = 1'b1;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("restart req",  mem_if.req,  1'b1);
    check("restart addr", mem_if.addr, 32'h0);
    @(posedge clk_i);
    #1;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = idata(32'h0);
    @(posedge clk_i);
    #1;
    mem_if.rvalid = 1'b0;
    @(negedge clk_i);
    check("restart valid", instr_valid_o, 1'b1);
    check("restart pc",    pc_o,          32'h0);
    check("restart instr", instr_o,       idata(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
